// File: rtl/uart_pkg.sv
// Shared UART definitions: one-cold FSM encodings, parity modes and default bit timing.
package uart_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b11110,
        ST_START  = 5'b11101,
        ST_DATA   = 5'b11011,
        ST_PARITY = 5'b10111,
        ST_STOP   = 5'b01111
    } uart_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    localparam int unsigned TICKS_PER_BIT_DEF = 16;
    localparam int unsigned STOP_TICKS_DEF    = 16;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop period,
// all paced by the shared oversampling baud tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned SIZE_TRAMA_BIT   = 8,
    parameter int unsigned SIZE_BIT_COUNTER = 3,
    parameter int unsigned TICKS_PER_BIT    = TICKS_PER_BIT_DEF,
    parameter int unsigned STOP_TICKS       = STOP_TICKS_DEF,
    parameter int unsigned PARITY_MODE      = PARITY_NONE
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_tick,
    input  logic                      i_tx_start,
    input  logic [SIZE_TRAMA_BIT-1:0] i_data,
    output logic                      o_tx,
    output logic                      o_busy,
    output logic                      o_tx_done
);

    localparam int unsigned TICK_MAX = (TICKS_PER_BIT > STOP_TICKS) ? TICKS_PER_BIT : STOP_TICKS;
    localparam int unsigned TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

    localparam logic [TICK_W-1:0]           BIT_LAST_TICK  = TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0]           STOP_LAST_TICK = TICK_W'(STOP_TICKS - 1);
    localparam logic [SIZE_BIT_COUNTER-1:0] LAST_BIT       = SIZE_BIT_COUNTER'(SIZE_TRAMA_BIT - 1);
    localparam bit                          HAS_PARITY     = (PARITY_MODE != PARITY_NONE);

    uart_state_e                 state_q, state_d;
    logic [TICK_W-1:0]           tick_cnt_q, tick_cnt_d;
    logic [SIZE_BIT_COUNTER-1:0] bit_cnt_q, bit_cnt_d;
    logic [SIZE_TRAMA_BIT-1:0]   shift_q, shift_d;
    logic                        parity_q, parity_d;
    logic                        tx_q, tx_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; counters only advance on baud ticks.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_tx_start) begin
                    shift_d    = i_data;
                    parity_d   = (PARITY_MODE == PARITY_ODD) ? ~(^i_data) : (^i_data);
                    tick_cnt_d = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (tick_cnt_q == BIT_LAST_TICK) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (tick_cnt_q == BIT_LAST_TICK) begin
                        tick_cnt_d = '0;
                        shift_d    = shift_q >> 1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + SIZE_BIT_COUNTER'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (i_tick) begin
                    if (tick_cnt_q == BIT_LAST_TICK) begin
                        tick_cnt_d = '0;
                        state_d    = ST_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (i_tick) begin
                    if (tick_cnt_q == STOP_LAST_TICK) begin
                        tick_cnt_d = '0;
                        state_d    = ST_IDLE;
                        done_d     = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    // Line level is decoded from the next state so o_tx moves with the state register.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign o_tx      = tx_q;
    assign o_busy    = busy_q;
    assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (no/even/odd parity) and a byte scoreboard.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [2:0] start;
    logic [7:0] data;

    logic tx0, tx1, tx2;
    logic busy0, busy1, busy2;
    logic done0, done1, done2;

    wire [2:0] tx_v   = {tx2, tx1, tx0};
    wire [2:0] busy_v = {busy2, busy1, busy0};
    wire [2:0] done_v = {done2, done1, done0};

    int checks = 0;
    int errors = 0;
    int tick_div = 1;
    int phase = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx u_none (
        .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start[0]), .i_data(data),
        .o_tx(tx0), .o_busy(busy0), .o_tx_done(done0)
    );

    uart_tx #(.PARITY_MODE(1)) u_even (
        .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start[1]), .i_data(data),
        .o_tx(tx1), .o_busy(busy1), .o_tx_done(done1)
    );

    uart_tx #(.PARITY_MODE(2)) u_odd (
        .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start[2]), .i_data(data),
        .o_tx(tx2), .o_busy(busy2), .o_tx_done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        phase++;
        tick = ((phase % tick_div) == 0);
    endtask

    task automatic send(input int sel, input logic [7:0] d);
        start[sel] = 1'b1;
        data = d;
        exp_q.push_back(d);
        cyc();
        start[sel] = 1'b0;
        chk($sformatf("accept_tx_%02h", d), tx_v[sel], 1'b0);
        chk($sformatf("accept_busy_%02h", d), busy_v[sel], 1'b1);
    endtask

    // Record the line from the accept edge to o_tx_done and compare against the popped byte.
    task automatic check_frame(input int sel, input int cpb, input bit exact, input int inject);
        logic [7:0] d;
        logic       exp_bits[$];
        logic       samp[1024];
        int         n;
        int         total;
        bit         got;
        bit         ok;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        d = exp_q.pop_front();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        if (sel == 1) exp_bits.push_back(^d);
        else if (sel == 2) exp_bits.push_back(~(^d));
        exp_bits.push_back(1'b1);
        total = exp_bits.size() * cpb;
        n = 0;
        got = 1'b0;
        samp[0] = tx_v[sel];
        for (int c = 1; c < total + 8 && !got; c++) begin
            if (c == inject) begin
                start[0] = 1'b1;
                data = 8'hFF;
            end
            cyc();
            start[0] = 1'b0;
            if (done_v[sel]) begin
                got = 1'b1;
                n = c;
            end else if (c < 1024) begin
                samp[c] = tx_v[sel];
            end
        end
        if (!got) begin
            chk($sformatf("f%02h_done_timeout", d), 0, 1);
            return;
        end
        if (exact) chk($sformatf("f%02h_len", d), n, total);
        else chk($sformatf("f%02h_len_%0d", d, n), (n >= total - 3 && n <= total), 1);
        for (int b = 0; b < exp_bits.size(); b++) begin
            ok = 1'b1;
            if (exact) begin
                for (int c = b * cpb; c < (b + 1) * cpb; c++) begin
                    if (samp[c] !== exp_bits[b]) ok = 1'b0;
                end
            end else begin
                ok = (samp[b * cpb + cpb / 2] === exp_bits[b]);
            end
            chk($sformatf("f%02h_bit%0d_level_ok", d, b), ok, 1'b1);
        end
        chk($sformatf("f%02h_busy_at_done", d), busy_v[sel], 1'b0);
        chk($sformatf("f%02h_tx_at_done", d), tx_v[sel], 1'b1);
    endtask

    initial begin
        int hits;
        rst = 1'b0;
        tick = 1'b1;
        start = 3'b000;
        data = 8'h00;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", tx0, 1'b1);
        chk("reset_busy", busy0, 1'b0);
        chk("reset_done", done0, 1'b0);
        chk("reset_tx_par", {tx2, tx1}, 2'b11);
        rst = 1'b0;
        cyc();

        send(0, 8'hA5);
        check_frame(0, 16, 1'b1, -1);
        cyc();
        chk("a5_done_one_cycle", done0, 1'b0);

        send(1, 8'h07);
        check_frame(1, 16, 1'b1, -1);
        cyc();
        send(2, 8'h07);
        check_frame(2, 16, 1'b1, -1);
        cyc();

        send(0, 8'h3C);
        check_frame(0, 16, 1'b1, 50);
        cyc();
        chk("ignored_req_no_frame", busy0, 1'b0);

        send(0, 8'h11);
        check_frame(0, 16, 1'b1, -1);
        send(0, 8'h55);
        check_frame(0, 16, 1'b1, -1);
        cyc();

        tick_div = 4;
        send(0, 8'h00);
        check_frame(0, 64, 1'b0, -1);
        tick_div = 1;
        cyc();

        send(0, 8'h50);
        repeat (72) cyc();
        chk("mid_bit3_tx", tx0, 1'b0);
        chk("mid_bit3_busy", busy0, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_reset_tx", tx0, 1'b1);
        chk("async_reset_busy", busy0, 1'b0);
        void'(exp_q.pop_front());
        hits = 0;
        repeat (3) begin
            cyc();
            if (done0) hits++;
        end
        rst = 1'b0;
        repeat (200) begin
            cyc();
            if (done0) hits++;
        end
        chk("reset_no_done", hits, 0);

        send(0, 8'h81);
        check_frame(0, 16, 1'b1, -1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
